// File: rtl/rtl_sbc_bus_pkg.sv
// ---------------------------------------------------------------------------
// rtl_sbc_bus_pkg
//
// Shared definitions for the 6502-bus peripherals on the SBC.
//   - Register select values seen on A0.
//   - Bit positions inside the STATUS byte returned on a STATUS read.
//   - Bit positions inside the CTRL byte accepted on a CTRL write.
//   - A decoded access type and helpers that build/decode bus values.
// ---------------------------------------------------------------------------
package rtl_sbc_bus_pkg;

  // Register select (value of A0)
  localparam logic REG_DATA = 1'b0;
  localparam logic REG_STAT = 1'b1;

  // STATUS byte layout: {NOT_EMPTY, FULL, OVERFLOW, COUNT[4:0]}
  localparam int ST_NE      = 7;
  localparam int ST_FULL    = 6;
  localparam int ST_OVF     = 5;
  localparam int ST_CNT_MSB = 4;

  // CTRL byte layout
  localparam int CT_FLUSH  = 0;
  localparam int CT_IRQEN  = 1;
  localparam int CT_OVFCLR = 5;

  // Kind of CPU access, decoded from the captured R/W and A0
  typedef enum logic [1:0] {
    ACC_RD_DATA,
    ACC_RD_STAT,
    ACC_WR_DATA,
    ACC_WR_CTRL
  } access_e;

  // Classify a bus cycle from its R/W and register-select lines.
  function automatic access_e decode_access(input logic rw, input logic a0);
    access_e kind;
    if (rw) begin
      kind = (a0 == REG_STAT) ? ACC_RD_STAT : ACC_RD_DATA;
    end else begin
      kind = (a0 == REG_STAT) ? ACC_WR_CTRL : ACC_WR_DATA;
    end
    return kind;
  endfunction

  // Assemble the STATUS byte; the count is already zero-extended to 5 bits.
  function automatic logic [7:0] pack_status(input logic       not_empty,
                                             input logic       full,
                                             input logic       overflow,
                                             input logic [4:0] count);
    logic [7:0] s;
    s                  = '0;
    s[ST_NE]           = not_empty;
    s[ST_FULL]         = full;
    s[ST_OVF]          = overflow;
    s[ST_CNT_MSB:0]    = count;
    return s;
  endfunction

endpackage : rtl_sbc_bus_pkg

// File: rtl/rtl_sync_fifo.sv
// ---------------------------------------------------------------------------
// rtl_sync_fifo
//
// Small single-clock FIFO with a registered storage array and an
// occupancy counter. The head entry is always visible on 'head' (stale
// when empty), so a reader can look without popping.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (empties FIFO, clears storage)
//   push     in   write wr_data at the tail (ignored when full unless popping)
//   pop      in   drop the head entry (ignored when empty)
//   flush    in   empty the FIFO; wins over push and pop in the same cycle
//   wr_data  in   byte to push
//   head     out  entry at the read pointer
//   count    out  occupancy, 0 .. 2**DEPTH_LOG2
//   full     out  count == 2**DEPTH_LOG2
//   empty    out  count == 0
// ---------------------------------------------------------------------------
module rtl_sync_fifo #(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full  = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a push into a full FIFO
  // is still accepted when a pop happens alongside it.
  always_comb begin
    do_pop  = pop  & ~empty & ~flush;
    do_push = push & ~flush & (~full | do_pop);
  end

  // Storage, pointers and occupancy. Pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule : rtl_sync_fifo

// File: rtl/rtl_bus_rx_fifo_port.sv
// ---------------------------------------------------------------------------
// rtl_bus_rx_fifo_port
//
// Receive port on the 6502 bus. A peripheral pushes bytes into a small
// FIFO; the CPU reads them through DATA (A0=0) and STATUS/CTRL (A0=1).
// The CPU side is sampled through a PHI2 synchronizer: the access is
// captured while PHI2 is high and takes effect once its falling edge has
// been seen in the CLK domain.
//
// Ports:
//   clk       in   system clock, at least 4x PHI2
//   reset_n   in   asynchronous active-low reset
//   phi2      in   6502 phase-2 clock (asynchronous)
//   cs_n      in   chip select, active low
//   rw        in   1 = read, 0 = write
//   a0        in   register select: 0 = DATA, 1 = STATUS/CTRL
//   din       in   CPU write data
//   dout      out  read data toward the 3-state bus buffer
//   bus_oe_n  out  bus buffer output enable, active low (pure pin logic)
//   in_data   in   peripheral byte
//   in_stb    in   one-clk push strobe, polarity set by STB_ACTIVE
//   irq_n     out  interrupt request, active low, registered
// ---------------------------------------------------------------------------
module rtl_bus_rx_fifo_port
  import rtl_sbc_bus_pkg::*;
#(
  parameter int   DEPTH_LOG2 = 2,
  parameter logic STB_ACTIVE = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       phi2,
  input  logic       cs_n,
  input  logic       rw,
  input  logic       a0,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       bus_oe_n,
  input  logic [7:0] in_data,
  input  logic       in_stb,
  output logic       irq_n
);

  // PHI2 synchronizer and edge detection
  logic       phi2_s1;
  logic       phi2_s2;
  logic       phi2_d;
  logic [1:0] settle_cnt;
  logic       sync_ready;
  logic       phi2_rise;
  logic       phi2_fall;
  logic       armed;

  // Captured access (only the CTRL bits that matter are kept)
  logic       cap_cs_n;
  logic       cap_rw;
  logic       cap_a0;
  logic       cap_flush;
  logic       cap_irqen;
  logic       cap_ovfclr;

  // Commit decode
  access_e    acc_kind;
  logic       commit;
  logic       pop_req;
  logic       ctrl_wr;
  logic       flush_req;
  logic       push_req;
  logic       ovf_set;

  // Flags and FIFO view
  logic                overflow;
  logic                irq_en;
  logic [7:0]          head;
  logic [DEPTH_LOG2:0] count;
  logic                full;
  logic                empty;
  logic [7:0]          status;

  // CTRL bits with no function in this block
  logic din_unused;
  assign din_unused = ^{din[7:6], din[4:2]};

  // The bus buffer must react within the PHI2 high phase, so it is driven
  // straight from the pins with no clocked path.
  assign bus_oe_n = cs_n | ~rw | ~phi2;

  // Read data is a mux over registered state; reading DATA never pops here,
  // the pop only happens at commit time.
  assign status = pack_status(~empty, full, overflow, 5'(count));
  assign dout   = (a0 == REG_STAT) ? status : head;

  // Edges are ignored until the synchronizer and the delayed copy hold real
  // samples after reset. Without this, PHI2 held high through reset would
  // look like a fresh rising edge and a half-seen access could commit.
  assign sync_ready = (settle_cnt == 2'd3);
  assign phi2_rise  = sync_ready &  phi2_s2 & ~phi2_d;
  assign phi2_fall  = sync_ready & ~phi2_s2 &  phi2_d;

  always_comb begin
    acc_kind  = decode_access(cap_rw, cap_a0);
    commit    = phi2_fall & armed & ~cap_cs_n;
    pop_req   = commit & (acc_kind == ACC_RD_DATA);
    ctrl_wr   = commit & (acc_kind == ACC_WR_CTRL);
    flush_req = ctrl_wr & cap_flush;
    push_req  = (in_stb == STB_ACTIVE);
    // A push is lost only when the FIFO is full and no pop makes room.
    // A flush in the same cycle drops the byte without flagging overflow.
    ovf_set   = push_req & full & ~(pop_req & ~empty) & ~flush_req;
  end

  // Synchronize PHI2 and track whether a whole access (rise then fall) has
  // been observed since reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phi2_s1    <= 1'b0;
      phi2_s2    <= 1'b0;
      phi2_d     <= 1'b0;
      settle_cnt <= 2'd0;
      armed      <= 1'b0;
    end else begin
      phi2_s1 <= phi2;
      phi2_s2 <= phi2_s1;
      phi2_d  <= phi2_s2;
      if (settle_cnt != 2'd3) begin
        settle_cnt <= settle_cnt + 2'd1;
      end
      if (phi2_rise) begin
        armed <= 1'b1;
      end else if (phi2_fall) begin
        armed <= 1'b0;
      end
    end
  end

  // Keep refreshing the access while synced PHI2 is high; the last sample
  // before the fall is the one that commits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_cs_n   <= 1'b1;
      cap_rw     <= 1'b1;
      cap_a0     <= REG_DATA;
      cap_flush  <= 1'b0;
      cap_irqen  <= 1'b0;
      cap_ovfclr <= 1'b0;
    end else if (phi2_s2) begin
      cap_cs_n   <= cs_n;
      cap_rw     <= rw;
      cap_a0     <= a0;
      cap_flush  <= din[CT_FLUSH];
      cap_irqen  <= din[CT_IRQEN];
      cap_ovfclr <= din[CT_OVFCLR];
    end
  end

  // Sticky overflow (a new overflow beats a clear in the same cycle),
  // interrupt enable, and the registered interrupt output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      irq_en   <= 1'b0;
      irq_n    <= 1'b1;
    end else begin
      overflow <= ovf_set | (overflow & ~(ctrl_wr & cap_ovfclr));
      if (ctrl_wr) begin
        irq_en <= cap_irqen;
      end
      irq_n <= ~(irq_en & ~empty);
    end
  end

  rtl_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push    (push_req),
    .pop     (pop_req),
    .flush   (flush_req),
    .wr_data (in_data),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

endmodule : rtl_bus_rx_fifo_port

// File: tb/tb_rtl_bus_rx_fifo_port.sv
// ---------------------------------------------------------------------------
// tb_rtl_bus_rx_fifo_port
//
// Drives the receive port with directed and randomized CPU bus cycles and
// peripheral pushes. A queue-based model of the port tracks the FIFO
// contents, flags and interrupt; every cycle the outputs are compared to it.
// Directed sections add fixed literal expectations.
// ---------------------------------------------------------------------------
module tb_rtl_bus_rx_fifo_port;

  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       phi2;
  logic       cs_n;
  logic       rw;
  logic       a0;
  logic [7:0] din;
  logic [7:0] dout;
  logic       bus_oe_n;
  logic [7:0] in_data;
  logic       in_stb;
  logic       irq_n;

  int checks   = 0;
  int failures = 0;

  // Model state
  byte unsigned fifo_q[$];
  bit           m_ovf        = 1'b0;
  bit           m_irq_en     = 1'b0;
  bit           m_irq_n_exp  = 1'b1;
  bit           m_prev_phi2  = 1'b1;
  bit           m_armed      = 1'b0;
  int           m_pending    = 0;
  bit           cap_cs_n, cap_rw, cap_a0;
  logic [7:0]   cap_din;
  bit           com_cs_n, com_rw, com_a0;
  logic [7:0]   com_din;
  bit           rand_en      = 1'b0;

  always #5 clk = ~clk;

  rtl_bus_rx_fifo_port #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .STB_ACTIVE (1'b1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .phi2     (phi2),
    .cs_n     (cs_n),
    .rw       (rw),
    .a0       (a0),
    .din      (din),
    .dout     (dout),
    .bus_oe_n (bus_oe_n),
    .in_data  (in_data),
    .in_stb   (in_stb),
    .irq_n    (irq_n)
  );

  function automatic logic [7:0] exp_status();
    int n;
    n = fifo_q.size();
    return {n != 0, n == DEPTH, m_ovf, 5'(n)};
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%02h expected=0x%02h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Port behaviour at one clock edge: the CPU access commits on the third
  // edge after the PHI2 pin is seen low, IRQ follows state one edge late.
  task automatic model_edge();
    int  sz;
    bit  commit, pop, wctl, flush, ovf_set;
    if (!reset_n) begin
      fifo_q.delete();
      m_ovf       = 1'b0;
      m_irq_en    = 1'b0;
      m_irq_n_exp = 1'b1;
      m_prev_phi2 = 1'b1;
      m_armed     = 1'b0;
      m_pending   = 0;
      return;
    end
    m_irq_n_exp = !(m_irq_en && fifo_q.size() != 0);
    commit = 1'b0;
    if (m_pending > 0) begin
      m_pending--;
      if (m_pending == 0) commit = 1'b1;
    end
    if (m_prev_phi2 && !phi2) begin
      if (m_armed) begin
        m_pending = 2;
        com_cs_n  = cap_cs_n;
        com_rw    = cap_rw;
        com_a0    = cap_a0;
        com_din   = cap_din;
      end
      m_armed = 1'b0;
    end else if (!m_prev_phi2 && phi2) begin
      m_armed = 1'b1;
    end
    if (phi2) begin
      cap_cs_n = cs_n;
      cap_rw   = rw;
      cap_a0   = a0;
      cap_din  = din;
    end
    m_prev_phi2 = phi2;

    sz      = fifo_q.size();
    pop     = commit && !com_cs_n && com_rw && !com_a0 && sz > 0;
    wctl    = commit && !com_cs_n && !com_rw && com_a0;
    flush   = wctl && com_din[0];
    ovf_set = 1'b0;
    if (flush) begin
      fifo_q.delete();
    end else begin
      if (pop) void'(fifo_q.pop_front());
      if (in_stb) begin
        if (sz < DEPTH || pop) fifo_q.push_back(in_data);
        else                   ovf_set = 1'b1;
      end
    end
    if (wctl && com_din[5]) m_ovf = 1'b0;
    if (ovf_set)            m_ovf = 1'b1;
    if (wctl)               m_irq_en = com_din[1];
  endtask

  task automatic compare_now();
    if (!reset_n) return;
    checkOutput("bus_oe_n", {7'b0, bus_oe_n}, {7'b0, cs_n | ~rw | ~phi2});
    checkOutput("irq_n", {7'b0, irq_n}, {7'b0, m_irq_n_exp});
    if (a0) checkOutput("status", dout, exp_status());
    else if (fifo_q.size() != 0) checkOutput("data_head", dout, fifo_q[0]);
  endtask

  // One clock: compare at the falling edge, advance the model at the rising
  // edge, then drive the next inputs 2 ns later.
  task automatic tick();
    @(negedge clk);
    compare_now();
    @(posedge clk);
    model_edge();
    #2;
    if (rand_en) begin
      in_stb  = ($urandom_range(0, 5) == 0);
      in_data = 8'($urandom);
    end else begin
      in_stb = 1'b0;
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    in_stb  = 1'b1;
    in_data = d;
    tick();
  endtask

  task automatic phase_high(input logic c, input logic r, input logic a,
                            input logic [7:0] d);
    cs_n = c;
    rw   = r;
    a0   = a;
    din  = d;
    phi2 = 1'b1;
    repeat (4) tick();
  endtask

  task automatic phase_low();
    phi2 = 1'b0;
    repeat (4) tick();
    cs_n = 1'b1;
    rw   = 1'b1;
  endtask

  task automatic applyStimulus(input logic c, input logic r, input logic a,
                               input logic [7:0] d);
    phase_high(c, r, a, d);
    phase_low();
  endtask

  // Full-FIFO or empty-FIFO DATA read with a push landing on the commit edge.
  task automatic pop_with_push(input logic [7:0] d);
    phase_high(1'b0, 1'b1, 1'b0, 8'h00);
    phi2 = 1'b0;
    tick();
    tick();
    in_stb  = 1'b1;
    in_data = d;
    tick();
    tick();
    cs_n = 1'b1;
    rw   = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_drain [4];
    logic [7:0] r;

    reset_n = 1'b0;
    phi2    = 1'b0;
    cs_n    = 1'b1;
    rw      = 1'b1;
    a0      = 1'b1;
    din     = 8'h00;
    in_stb  = 1'b0;
    in_data = 8'h00;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (5) tick();

    // Reset state and output-enable gating
    phase_high(1'b0, 1'b1, 1'b1, 8'h00);
    settle();
    checkOutput("rst_oe_sel_read", {7'b0, bus_oe_n}, 8'h00);
    checkOutput("rst_status", dout, 8'h00);
    checkOutput("rst_irq_n", {7'b0, irq_n}, 8'h01);
    cs_n = 1'b1;
    settle();
    checkOutput("oe_unselected", {7'b0, bus_oe_n}, 8'h01);
    cs_n = 1'b0;
    rw   = 1'b0;
    settle();
    checkOutput("oe_write", {7'b0, bus_oe_n}, 8'h01);
    rw = 1'b1;
    phase_low();

    // Two pushes, then one DATA read
    push_byte(8'h41);
    push_byte(8'h42);
    a0 = 1'b1;
    settle();
    checkOutput("two_push_status", dout, 8'h82);
    phase_high(1'b0, 1'b1, 1'b0, 8'h00);
    settle();
    checkOutput("read_head_41", dout, 8'h41);
    phase_low();
    settle();
    checkOutput("after_pop_head_42", dout, 8'h42);
    a0 = 1'b1;
    settle();
    checkOutput("after_pop_status", dout, 8'h81);

    // Overflow, overflow clear, drain
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h21);
    for (int i = 0; i < 5; i++) push_byte(8'(8'h10 + i));
    a0 = 1'b1;
    settle();
    checkOutput("overflow_status", dout, 8'hE4);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h20);
    settle();
    checkOutput("ovf_clear_status", dout, 8'hC4);
    for (int i = 0; i < 4; i++) begin
      phase_high(1'b0, 1'b1, 1'b0, 8'h00);
      settle();
      checkOutput("drain_byte", dout, 8'(8'h10 + i));
      phase_low();
    end
    a0 = 1'b1;
    settle();
    checkOutput("drained_status", dout, 8'h00);

    // Interrupt enable and timing
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h02);
    settle();
    checkOutput("irq_en_empty", {7'b0, irq_n}, 8'h01);
    push_byte(8'h55);
    settle();
    checkOutput("irq_same_clk", {7'b0, irq_n}, 8'h01);
    tick();
    settle();
    checkOutput("irq_asserted", {7'b0, irq_n}, 8'h00);
    phase_high(1'b0, 1'b1, 1'b0, 8'h00);
    settle();
    checkOutput("irq_read_55", dout, 8'h55);
    phase_low();
    settle();
    checkOutput("irq_released", {7'b0, irq_n}, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);

    // Pop and push together on a full FIFO, then on an empty one
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h21);
    for (int i = 0; i < 4; i++) push_byte(8'(8'hA0 + i));
    pop_with_push(8'h99);
    a0 = 1'b1;
    settle();
    checkOutput("full_pop_push_status", dout, 8'hC4);
    exp_drain[0] = 8'hA1;
    exp_drain[1] = 8'hA2;
    exp_drain[2] = 8'hA3;
    exp_drain[3] = 8'h99;
    for (int i = 0; i < 4; i++) begin
      phase_high(1'b0, 1'b1, 1'b0, 8'h00);
      settle();
      checkOutput("full_drain", dout, exp_drain[i]);
      phase_low();
    end
    pop_with_push(8'h99);
    a0 = 1'b1;
    settle();
    checkOutput("empty_pop_push_status", dout, 8'h81);
    a0 = 1'b0;
    settle();
    checkOutput("empty_pop_push_head", dout, 8'h99);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h21);

    // Reset in the middle of a DATA read
    for (int i = 0; i < 3; i++) push_byte(8'(8'hC0 + i));
    cs_n = 1'b0;
    rw   = 1'b1;
    a0   = 1'b0;
    phi2 = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    a0      = 1'b1;
    settle();
    checkOutput("reset_mid_status", dout, 8'h00);
    checkOutput("reset_mid_oe", {7'b0, bus_oe_n}, 8'h00);
    tick();
    tick();
    reset_n = 1'b1;
    a0      = 1'b0;
    tick();
    push_byte(8'h77);
    tick();
    phase_low();
    a0 = 1'b1;
    settle();
    checkOutput("no_pop_after_reset", dout, 8'h81);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h21);

    // Randomized bus cycles with random peripheral pushes
    rand_en = 1'b1;
    for (int n = 0; n < 90; n++) begin
      r    = 8'($urandom);
      r[0] = ($urandom_range(0, 7) == 0);
      applyStimulus($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), r);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) tick();
    end
    rand_en = 1'b0;
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rtl_bus_rx_fifo_port

// File: doc/rtl_bus_rx_fifo_port.md
Name: rtl_bus_rx_fifo_port

Overview:
6502-bus-attached receive port. A peripheral (keyboard, serial deserializer) pushes bytes into a small FIFO. The CPU reads them through two registers (DATA, STATUS/CTRL).
The block produces the read-data byte and the active-low output-enable that drive the board's octal 3-state data-bus buffer directly upstream of the CPU data bus. It also raises an active-low IRQ.

Parameters:
DEPTH_LOG2, 2, log2 of FIFO depth (4 entries); legal range 1..4.
STB_ACTIVE, 1, polarity of IN_STB (1 = active-high pulse).

Ports:
CLK  in  1  system clock; must be at least 4x PHI2.
RESET_N  in  1  asynchronous active-low reset.
PHI2  in  1  6502 phase-2 clock, asynchronous to CLK.
CS_N  in  1  chip select, active low.
RW  in  1  6502 R/W (1 = read).
A0  in  1  register select: 0 = DATA, 1 = STATUS/CTRL.
DIN  in  8  CPU write data.
DOUT  out  8  read data toward the 3-state buffer D input.
BUS_OE_N  out  1  buffer output enable, active low.
IN_DATA  in  8  peripheral byte.
IN_STB  in  1  one-CLK push strobe, synchronous to CLK.
IRQ_N  out  1  interrupt request, active low, registered.

Behaviour:
- Reset (async, RESET_N=0):
  - FIFO emptied, pointers 0, count 0.
  - OVERFLOW=0, IRQ_EN=0, IRQ_N=1.
  - PHI2 synchronizer and capture registers cleared.
  - DOUT = head entry (0x00 after reset).
  - Reset mid-access: the pending pop is discarded.
- BUS_OE_N:
  - Combinational: BUS_OE_N = CS_N | ~RW | ~PHI2, from raw pins.
  - No CLK latency, so the buffer drives only during PHI2 high of a selected read.
- DOUT:
  - Combinational from registered state.
  - A0=0: head entry (stale head if empty; no pop side effect).
  - A0=1: STATUS = {NOT_EMPTY, FULL, OVERFLOW, COUNT[4:0]}, with COUNT zero-extended.
- PHI2 handling:
  - 2-FF synchronizer, then falling-edge detect.
  - While synced PHI2=1, capture CS_N, RW, A0, DIN on every CLK.
  - On the detected falling edge, the last captured access commits. Effect is 3-4 CLK after the PHI2 fall.
- Commit actions (only when captured CS_N=0):
  - Read DATA: pop if NOT_EMPTY; pop on empty is a no-op.
  - Read STATUS: no side effect.
  - Write DATA: ignored.
  - Write CTRL:
    - DIN[0]=1 flushes the FIFO (count 0, pointers equal).
    - DIN[5]=1 clears OVERFLOW.
    - DIN[1] loads IRQ_EN.
- Push:
  - IN_STB asserted at a CLK edge writes IN_DATA at the write pointer when not FULL.
  - If FULL, the byte is dropped and OVERFLOW is set (sticky).
- Simultaneous events in one CLK:
  - Pop + push when FULL: both happen; byte accepted; no overflow.
  - Pop + push when empty: push accepted; pop is a no-op; count becomes 1.
  - Flush + push: flush wins; byte dropped; OVERFLOW unchanged.
  - OVERFLOW set + clear: set wins.
- Pointers wrap modulo 2^DEPTH_LOG2. Count range is 0..2^DEPTH_LOG2.
- FULL = (count == 2^DEPTH_LOG2). NOT_EMPTY = (count != 0).
- IRQ_N: registered, = ~(IRQ_EN & NOT_EMPTY), updated one CLK after the state change.

Decomposition:
- Package rtl_sbc_bus_pkg holds:
  - register addresses: REG_DATA = 0, REG_STAT = 1;
  - status bit positions: ST_NE = 7, ST_FULL = 6, ST_OVF = 5, ST_CNT_MSB = 4;
  - CTRL bit positions: CT_FLUSH = 0, CT_IRQEN = 1, CT_OVFCLR = 5.
- Sub-module rtl_sync_fifo (DEPTH_LOG2, 8-bit):
  - inputs: push, pop, flush;
  - outputs: head, count, full, empty.
- Top level holds the PHI2 synchronizer, access capture/commit, flags, IRQ and output muxing.

Test Plan:
- Reset, then read STATUS with CS_N=0, RW=1, A0=1, PHI2 high → BUS_OE_N=0 while PHI2 high, DOUT=0x00, IRQ_N=1. With CS_N=1 or RW=0 → BUS_OE_N=1.
- Push 0x41, 0x42 via IN_STB → STATUS=0x82. DATA read shows DOUT=0x41; after PHI2 fall and ≤4 CLK, DOUT shows 0x42 and STATUS=0x81.
- Push 5 bytes 0x10..0x14 at DEPTH_LOG2=2 → STATUS=0xE4 (0x14 dropped). Write CTRL 0x20 → STATUS=0xC4. Drain 4 DATA reads → 0x10..0x13, STATUS=0x00.
- Write CTRL 0x02 while empty → IRQ_N=1. Push 0x55 → IRQ_N=0 one CLK later. Read DATA → IRQ_N=1 after the commit.
- FULL plus IN_STB=0x99 in the same CLK as a DATA pop commit → no overflow, count stays 4, 0x99 is the last entry read. Repeat on empty: count 1, head 0x99.
- Assert RESET_N=0 during PHI2 high of a DATA read with FIFO count 3 → immediate STATUS=0x00. No pop occurs after release; BUS_OE_N still follows the pins.
